// File: rtl/babbage_inverse_h_pkg.sv
// Shared constants and state encoding for the Babbage h(n) = n^3+2n^2+2n+1 engines.
// Both the forward evaluator and the inverse search import this package.
package babbage_h_pkg;

  localparam int W_IN = 20;
  localparam int W_N  = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Seeds of the difference table at n=0: h(0), h(1)-h(0), second difference, third difference.
  localparam logic [W_IN-1:0] H0    = W_IN'(1);
  localparam logic [W_IN-1:0] F1    = W_IN'(5);
  localparam logic [W_IN-1:0] G2    = W_IN'(10);
  localparam logic [W_IN-1:0] G_INC = W_IN'(6);
  localparam logic [W_N-1:0]  N_MAX = '1;

endpackage

// File: rtl/babbage_inverse_h_if.sv
// Start/done handshake bundle for the inverse h(n) search.
interface babbage_inverse_h_if;
  import babbage_h_pkg::*;

  logic            start_i;
  logic [W_IN-1:0] in_i;
  logic            ready_o;
  logic            done_tick_o;
  logic [W_N-1:0]  out_o;
  logic            exact_o;
  logic            under_o;

  modport master (
    output start_i, in_i,
    input  ready_o, done_tick_o, out_o, exact_o, under_o
  );

  modport slave (
    input  start_i, in_i,
    output ready_o, done_tick_o, out_o, exact_o, under_o
  );

endinterface

// File: rtl/babbage_inverse_h_diff_step.sv
// Finite-difference register bank: holds i, h(i), first and second differences,
// and advances them one step per enable without any multiplier.
module babbage_diff_step
  import babbage_h_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              step_i,
  output logic [W_N-1:0]    i_o,
  output logic [W_IN-1:0]   h_o,
  output logic [W_IN:0]     sum_o
);

  logic [W_N-1:0]  i_q;
  logic [W_IN-1:0] h_q, f_q, g_q;

  // Extra bit keeps h+f from wrapping near the top of the 20-bit range.
  assign sum_o = {1'b0, h_q} + {1'b0, f_q};
  assign i_o   = i_q;
  assign h_o   = h_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_q <= '0;
      h_q <= '0;
      f_q <= '0;
      g_q <= '0;
    end else if (load_i) begin
      i_q <= '0;
      h_q <= H0;
      f_q <= F1;
      g_q <= G2;
    end else if (step_i) begin
      i_q <= i_q + W_N'(1);
      h_q <= sum_o[W_IN-1:0];
      f_q <= f_q + g_q;
      g_q <= g_q + G_INC;
    end
  end

endmodule

// File: rtl/babbage_inverse_h.sv
// Inverse of h(n): returns the largest n in 0..63 with h(n) <= y by walking the
// difference table upward until the next value would exceed y.
module babbage_inverse_h
  import babbage_h_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  babbage_inverse_h_if.slave  bus
);

  state_t          state_q, state_d;
  logic [W_IN-1:0] y_q, y_d;
  logic [W_N-1:0]  out_q, out_d;
  logic            exact_q, exact_d;
  logic            under_q, under_d;
  logic            load, step;

  logic [W_N-1:0]  i_cur;
  logic [W_IN-1:0] h_cur;
  logic [W_IN:0]   sum;

  babbage_diff_step u_step (
    .clk    (clk),
    .reset  (reset),
    .load_i (load),
    .step_i (step),
    .i_o    (i_cur),
    .h_o    (h_cur),
    .sum_o  (sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      out_q   <= '0;
      exact_q <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      out_q   <= out_d;
      exact_q <= exact_d;
      under_q <= under_d;
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    out_d   = out_q;
    exact_d = exact_q;
    under_d = under_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          y_d = bus.in_i;
          if (bus.in_i == '0) begin
            under_d = 1'b1;
            out_d   = '0;
            exact_d = 1'b0;
            state_d = ST_DONE;
          end else begin
            under_d = 1'b0;
            load    = 1'b1;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        // Stop when h(i+1) would overshoot y, or saturate at the top index.
        if (sum > {1'b0, y_q} || i_cur == N_MAX) begin
          out_d   = i_cur;
          exact_d = (h_cur == y_q);
          state_d = ST_DONE;
        end else begin
          step = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ready_o     = (state_q == ST_IDLE);
  assign bus.done_tick_o = (state_q == ST_DONE);
  assign bus.out_o       = out_q;
  assign bus.exact_o     = exact_q;
  assign bus.under_o     = under_q;

endmodule

// File: tb/tb_babbage_inverse_h.sv
// Bench for the inverse h(n) search: directed table, full sweep, random targets and protocol cases.
module tb_babbage_inverse_h;
  import babbage_h_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  babbage_inverse_h_if bus();
  babbage_inverse_h dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  function automatic int h_of(int n);
    return n*n*n + 2*n*n + 2*n + 1;
  endfunction

  function automatic int model_n(int y);
    int r = 0;
    for (int n = 0; n <= 63; n++) if (h_of(n) <= y) r = n;
    return r;
  endfunction

  function automatic int model_lat(int y);
    return (y == 0) ? 1 : model_n(y) + 2;
  endfunction

  // Start raised just after edge k; lat counts edges until done_tick is seen (-1 on timeout).
  task automatic do_search(input int y, output int n_o, output bit ex_o,
                           output bit un_o, output int lat, output bit rdy_bad);
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.in_i    = y[W_IN-1:0];
    rdy_bad = 1'b0;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    lat = 1;
    forever begin
      if (bus.ready_o !== 1'b0) rdy_bad = 1'b1;
      if (bus.done_tick_o === 1'b1) break;
      if (lat >= 100) break;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.done_tick_o !== 1'b1) lat = -1;
    n_o  = int'(bus.out_o);
    ex_o = bus.exact_o;
    un_o = bus.under_o;
  endtask

  task automatic test_reset();
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.ready_o); end
    checks++; if (bus.done_tick_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done_tick_o); end
    checks++; if (bus.out_o !== '0) begin errors++; $display("FAIL reset_out got %0d exp 0", bus.out_o); end
    checks++; if (bus.exact_o !== 1'b0) begin errors++; $display("FAIL reset_exact got %b exp 0", bus.exact_o); end
    checks++; if (bus.under_o !== 1'b0) begin errors++; $display("FAIL reset_under got %b exp 0", bus.under_o); end
  endtask

  task automatic test_directed();
    int ys[9]   = '{52, 51, 53, 5, 6, 0, 1, 258112, 1048575};
    int outs[9] = '{3, 2, 3, 0, 1, 0, 0, 63, 63};
    bit exs[9]  = '{1, 0, 0, 0, 1, 0, 1, 1, 0};
    bit uns[9]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    int lats[9] = '{5, 4, 5, 2, 3, 1, 2, 65, 65};
    int n; bit ex, un, rb; int lat;
    for (int k = 0; k < 9; k++) begin
      do_search(ys[k], n, ex, un, lat, rb);
      checks++; if (n !== outs[k]) begin errors++; $display("FAIL dir_out y=%0d got %0d exp %0d", ys[k], n, outs[k]); end
      checks++; if (ex !== exs[k]) begin errors++; $display("FAIL dir_exact y=%0d got %b exp %b", ys[k], ex, exs[k]); end
      checks++; if (un !== uns[k]) begin errors++; $display("FAIL dir_under y=%0d got %b exp %b", ys[k], un, uns[k]); end
      checks++; if (lat !== lats[k]) begin errors++; $display("FAIL dir_latency y=%0d got %0d exp %0d", ys[k], lat, lats[k]); end
      checks++; if (rb !== 1'b0) begin errors++; $display("FAIL dir_ready_busy y=%0d got %b exp 0", ys[k], rb); end
      @(posedge clk); #1;
      checks++; if (bus.done_tick_o !== 1'b0 || bus.ready_o !== 1'b1) begin
        errors++; $display("FAIL dir_pulse y=%0d done=%b ready=%b exp done=0 ready=1", ys[k], bus.done_tick_o, bus.ready_o);
      end
      checks++; if (int'(bus.out_o) !== outs[k]) begin errors++; $display("FAIL dir_hold y=%0d got %0d exp %0d", ys[k], bus.out_o, outs[k]); end
    end
  endtask

  task automatic test_sweep();
    int n; bit ex, un, rb; int lat; int y;
    for (int m = 0; m <= 63; m++) begin
      y = h_of(m);
      do_search(y, n, ex, un, lat, rb);
      checks++; if (n !== m || ex !== 1'b1 || un !== 1'b0 || lat !== m + 2) begin
        errors++; $display("FAIL sweep_hit y=%0d got n=%0d ex=%b un=%b lat=%0d exp n=%0d ex=1 un=0 lat=%0d", y, n, ex, un, lat, m, m + 2);
      end
      if (m >= 1) begin
        do_search(y - 1, n, ex, un, lat, rb);
        checks++; if (n !== m - 1 || ex !== 1'b0 || un !== 1'b0 || lat !== m + 1) begin
          errors++; $display("FAIL sweep_below y=%0d got n=%0d ex=%b lat=%0d exp n=%0d ex=0 lat=%0d", y - 1, n, ex, lat, m - 1, m + 1);
        end
      end
    end
  endtask

  task automatic test_random();
    int n; bit ex, un, rb; int lat; int y; int en; bit eex, eun;
    for (int k = 0; k < 40; k++) begin
      y = (k % 2 == 0) ? int'($urandom_range(0, 300)) : int'($urandom_range(0, 20'hFFFFF));
      en  = model_n(y);
      eun = (y == 0);
      eex = !eun && (h_of(en) == y);
      do_search(y, n, ex, un, lat, rb);
      checks++; if (n !== en || ex !== eex || un !== eun || lat !== model_lat(y)) begin
        errors++; $display("FAIL random y=%0d got n=%0d ex=%b un=%b lat=%0d exp n=%0d ex=%b un=%b lat=%0d",
                           y, n, ex, un, lat, en, eex, eun, model_lat(y));
      end
    end
  endtask

  task automatic test_busy_start();
    int lat; int en;
    en = model_n(100000);
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.in_i = 20'd100000;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1; bus.start_i = 1'b1; bus.in_i = 20'd5;
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.in_i = 20'd7;
    lat = 0;
    while (bus.done_tick_o !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++; if (bus.done_tick_o !== 1'b1) begin errors++; $display("FAIL busy_done timeout got 0 exp 1"); end
    checks++; if (int'(bus.out_o) !== en || bus.exact_o !== 1'b0) begin
      errors++; $display("FAIL busy_result got n=%0d ex=%b exp n=%0d ex=0", bus.out_o, bus.exact_o, en);
    end
    repeat (4) begin
      @(posedge clk); #1;
      checks++; if (bus.ready_o !== 1'b1 || bus.done_tick_o !== 1'b0) begin
        errors++; $display("FAIL busy_no_restart ready=%b done=%b exp ready=1 done=0", bus.ready_o, bus.done_tick_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n; bit ex, un, rb; int lat; bit seen;
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.in_i = 20'hFFFFF;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++; if (bus.ready_o !== 1'b1 || bus.done_tick_o !== 1'b0) begin
      errors++; $display("FAIL midreset_ctrl ready=%b done=%b exp ready=1 done=0", bus.ready_o, bus.done_tick_o);
    end
    checks++; if (bus.out_o !== '0 || bus.exact_o !== 1'b0 || bus.under_o !== 1'b0) begin
      errors++; $display("FAIL midreset_outs out=%0d ex=%b un=%b exp 0 0 0", bus.out_o, bus.exact_o, bus.under_o);
    end
    @(posedge clk); #1 reset = 1'b0;
    seen = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (bus.done_tick_o !== 1'b0) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_no_done got 1 exp 0"); end
    do_search(1000, n, ex, un, lat, rb);
    checks++; if (n !== model_n(1000) || lat !== model_lat(1000)) begin
      errors++; $display("FAIL midreset_recover got n=%0d lat=%0d exp n=%0d lat=%0d", n, lat, model_n(1000), model_lat(1000));
    end
  endtask

  task automatic test_back_to_back();
    int n; bit ex, un, rb; int lat;
    do_search(52, n, ex, un, lat, rb);
    checks++; if (n !== 3 || ex !== 1'b1 || lat !== 5) begin
      errors++; $display("FAIL b2b_first got n=%0d ex=%b lat=%0d exp n=3 ex=1 lat=5", n, ex, lat);
    end
    do_search(258112, n, ex, un, lat, rb);
    checks++; if (n !== 63 || ex !== 1'b1 || lat !== 65) begin
      errors++; $display("FAIL b2b_second got n=%0d ex=%b lat=%0d exp n=63 ex=1 lat=65", n, ex, lat);
    end
    do_search(0, n, ex, un, lat, rb);
    checks++; if (un !== 1'b1 || n !== 0 || ex !== 1'b0 || lat !== 1) begin
      errors++; $display("FAIL b2b_under got un=%b n=%0d ex=%b lat=%0d exp un=1 n=0 ex=0 lat=1", un, n, ex, lat);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i = 1'b0;
    bus.in_i    = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    test_directed();
    test_sweep();
    test_random();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
